// File: rtl/alu_sequencer.sv
// Command/response sequencer that drives an external registered ALU and captures its result.
// Optional operand chaining from the previous result is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_sequencer #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_sel,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_cin,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       cmd_chain,
`endif
    output logic [4:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    input  logic [7:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_count;
    logic       accept;
    logic       capture;
    logic       done;
    logic [7:0] next_a;

`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0] last_result;
    assign next_a = cmd_chain ? last_result : cmd_a;
`else
    assign next_a = cmd_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // cmd_ready is gated by rst so every output reads 0 for as long as reset is held.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                accept    = cmd_valid & ~rst;
                if (accept) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                capture = (wait_count == 4'd0);
                if (capture) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                done      = rsp_ready;
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The counter reaches zero ALU_LATENCY edges after acceptance; the following edge captures alu_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel    <= 5'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_cin    <= 1'b0;
            wait_count <= 4'd0;
            rsp_y      <= 8'd0;
            op_count   <= 16'd0;
`ifdef ALU_SEQ_CHAIN_EN
            last_result <= 8'd0;
`endif
        end else begin
            if (accept) begin
                alu_sel    <= cmd_sel;
                alu_a      <= next_a;
                alu_b      <= cmd_b;
                alu_cin    <= cmd_cin;
                wait_count <= 4'(ALU_LATENCY);
            end else if ((state == WAIT) && (wait_count != 4'd0)) begin
                wait_count <= wait_count - 4'd1;
            end
            if (capture) begin
                rsp_y <= alu_y;
`ifdef ALU_SEQ_CHAIN_EN
                last_result <= alu_y;
`endif
            end
            if (done) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule
